rice_bus_sram_slave: RTL and testbench



---
 rtl/rice_bus_sram_slave_if.sv | 27 ++
 rtl/rice_bus_sram_slave.sv | 131 +++++++++++++
 tb/tb_rice_bus_sram_slave.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rice_bus_sram_slave_if.sv
// Core data-bus link between a load/store master and a memory responder.
// Signal names are given from the responder's point of view.
interface rice_bus_sram_slave_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                    i_request_valid;
    logic                    o_request_ready;
    logic [ADDRESS_WIDTH-1:0] i_address;
    logic                    i_write;
    logic [DATA_WIDTH-1:0]   i_write_data;
    logic [DATA_WIDTH/8-1:0] i_strobe;
    logic                    o_response_valid;
    logic                    i_response_ready;
    logic [DATA_WIDTH-1:0]   o_read_data;
    logic                    o_error;

    modport master (
        output i_request_valid, i_address, i_write, i_write_data, i_strobe, i_response_ready,
        input  o_request_ready, o_response_valid, o_read_data, o_error
    );

    modport slave (
        input  i_request_valid, i_address, i_write, i_write_data, i_strobe, i_response_ready,
        output o_request_ready, o_response_valid, o_read_data, o_error
    );
endinterface

// File: rtl/rice_bus_sram_slave.sv
// Single-port word SRAM responder for the core data bus, one transaction in flight.
// Define RICE_BUS_SRAM_SLAVE_ERROR_RESPONSE_EN to flag out-of-range requests with o_error.
module rice_bus_sram_slave #(
    parameter int unsigned     ADDRESS_WIDTH = 32,
    parameter int unsigned     DATA_WIDTH    = 32,
    parameter int unsigned     MEMORY_DEPTH  = 1024,
    parameter longint unsigned BASE_ADDRESS  = 0,
    parameter int unsigned     WAIT_CYCLES   = 0
) (
    input logic                  i_clk,
    input logic                  i_rst,
    rice_bus_sram_slave_if.slave bus
);
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = $clog2(MEMORY_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] BaseAddr = ADDRESS_WIDTH'(BASE_ADDRESS);
    localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    ready_q, ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    error_q, error_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]    mem_q [MEMORY_DEPTH];
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [IdxW-1:0]          word_idx;
    logic                     in_range;
    logic                     accept;
    logic                     mem_we;

    assign offset   = bus.i_address - BaseAddr;
    assign word_idx = IdxW'(offset >> OffW);

`ifdef RICE_BUS_SRAM_SLAVE_ERROR_RESPONSE_EN
    localparam logic [ADDRESS_WIDTH:0] MemBytes =
        (ADDRESS_WIDTH + 1)'(longint'(MEMORY_DEPTH) * longint'(StrbW));
    // Base is aligned to the memory size, so addresses below base wrap to a large offset.
    assign in_range = {1'b0, offset} < MemBytes;
`else
    assign in_range = 1'b1;
`endif

    assign accept = ready_q & bus.i_request_valid & ~i_rst;
    assign mem_we = accept & bus.i_write & in_range;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    rdata_d = (bus.i_write || !in_range) ? '0 : mem_q[word_idx];
                    error_d = ~in_range;
                    ready_d = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_d     = StRespond;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = WaitInit;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d     = StRespond;
                    rsp_valid_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StRespond: begin
                if (bus.i_response_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    rdata_d     = '0;
                    error_d     = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                ready_d     = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 4'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    // Array is deliberately not reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < StrbW; b++) begin
                if (bus.i_strobe[b]) begin
                    mem_q[word_idx][8*b +: 8] <= bus.i_write_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.o_request_ready  = ready_q;
    assign bus.o_response_valid = rsp_valid_q;
    assign bus.o_read_data      = rdata_q;
    assign bus.o_error          = error_q;
endmodule

// File: tb/tb_rice_bus_sram_slave.sv
// Scoreboard bench: two responders (0 and 3 wait states) against a byte-array memory model.
`timescale 1ns/1ps
module tb_rice_bus_sram_slave;
    localparam int unsigned W0       = 0;
    localparam int unsigned W3       = 3;
    localparam int unsigned MemBytes = 4096;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        logic        err;
        int          mark;
        int          lat;
        int          stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid [2];
    logic [31:0] req_addr  [2];
    logic        req_write [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_strb  [2];
    logic        rsp_ready [2];
    logic        req_ready_s [2];
    logic        rsp_valid_s [2];
    logic [31:0] rdata_s     [2];
    logic        err_s       [2];
    bit          rand_ready  [2];

    rice_bus_sram_slave_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    rice_bus_sram_slave_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    rice_bus_sram_slave #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEMORY_DEPTH(1024),
        .BASE_ADDRESS(0), .WAIT_CYCLES(W0)
    ) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));

    rice_bus_sram_slave #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEMORY_DEPTH(1024),
        .BASE_ADDRESS(0), .WAIT_CYCLES(W3)
    ) dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));

    assign bus0.i_request_valid  = req_valid[0];
    assign bus0.i_address        = req_addr[0];
    assign bus0.i_write          = req_write[0];
    assign bus0.i_write_data     = req_wdata[0];
    assign bus0.i_strobe         = req_strb[0];
    assign bus0.i_response_ready = rsp_ready[0];
    assign bus3.i_request_valid  = req_valid[1];
    assign bus3.i_address        = req_addr[1];
    assign bus3.i_write          = req_write[1];
    assign bus3.i_write_data     = req_wdata[1];
    assign bus3.i_strobe         = req_strb[1];
    assign bus3.i_response_ready = rsp_ready[1];
    assign req_ready_s[0] = bus0.o_request_ready;
    assign rsp_valid_s[0] = bus0.o_response_valid;
    assign rdata_s[0]     = bus0.o_read_data;
    assign err_s[0]       = bus0.o_error;
    assign req_ready_s[1] = bus3.o_request_ready;
    assign rsp_valid_s[1] = bus3.o_response_valid;
    assign rdata_s[1]     = bus3.o_read_data;
    assign err_s[1]       = bus3.o_error;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] mdl_mem   [2][MemBytes];
    bit         mdl_known [2][MemBytes];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    function automatic string tag_of(input int k);
        return (k == 0) ? "w0" : "w3";
    endfunction

    function automatic int wait_of(input int k);
        return (k == 0) ? int'(W0) : int'(W3);
    endfunction

    // Memory seen as bytes; loads only compare bytes the bench has written.
    function automatic exp_t model(input int k, input logic [31:0] a, input bit wr,
                                   input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   base;
        e.data  = '0;
        e.mask  = '1;
        e.mark  = 0;
        e.lat   = 0;
        e.stall = 0;
`ifdef RICE_BUS_SRAM_SLAVE_ERROR_RESPONSE_EN
        e.err = (a >= MemBytes);
`else
        e.err = 1'b0;
`endif
        base = (int'(a % MemBytes) / 4) * 4;
        if (!e.err) begin
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) begin
                        mdl_mem[k][base+i]   = d[8*i +: 8];
                        mdl_known[k][base+i] = 1'b1;
                    end
                end
            end else begin
                e.mask = '0;
                for (int i = 0; i < 4; i++) begin
                    if (mdl_known[k][base+i]) begin
                        e.data[8*i +: 8] = mdl_mem[k][base+i];
                        e.mask[8*i +: 8] = 8'hFF;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic issue(input int k, input logic [31:0] a, input bit wr, input logic [31:0] d,
                         input logic [3:0] s, input int stall, input bit wait_done);
        exp_t  e;
        int    n;
        string tag;
        tag = tag_of(k);
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready_s[k] && n < 200);
        if (!req_ready_s[k]) begin
            n_checks++;
            $display("FAIL %s accept timeout: request_ready 0 for %0d cycles, expected 1", tag, n);
            return;
        end
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        req_write[k] = wr;
        req_wdata[k] = d;
        req_strb[k]  = s;
        e       = model(k, a, wr, d, s);
        e.mark  = cyc;
        e.lat   = 1 + wait_of(k);
        e.stall = stall;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
        req_write[k] = 1'($urandom);
        req_wdata[k] = $urandom;
        req_strb[k]  = 4'($urandom);
        if (!wait_done) return;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready_s[k] || n >= 200) break;
            n++;
        end
        if (!rand_ready[k]) check({tag, " busy cycles"}, n, 1 + wait_of(k) + stall);
        else if (n >= 200) check({tag, " completion timeout"}, n, 1 + wait_of(k));
    endtask

    task automatic monitor(input int k);
        bit          in_resp   = 1'b0;
        bit          just_done = 1'b0;
        int          stall_left = 0;
        exp_t        cur;
        logic [31:0] held_d;
        logic        held_e;
        string       tag;
        tag = tag_of(k);
        rsp_ready[k] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_resp      = 1'b0;
                just_done    = 1'b0;
                stall_left   = 0;
                rsp_ready[k] = 1'b0;
                if (k == 0) q0.delete();
                else q1.delete();
                continue;
            end
            if (just_done) begin
                check({tag, " idle ready after handshake"}, req_ready_s[k], 1);
                check({tag, " idle valid after handshake"}, rsp_valid_s[k], 0);
                just_done = 1'b0;
            end
            if (rsp_valid_s[k]) begin
                check({tag, " request_ready while responding"}, req_ready_s[k], 0);
                if (!in_resp) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        n_checks++;
                        $display("FAIL %s unexpected response: data 0x%08h, expected none",
                                 tag, rdata_s[k]);
                        cur.data = '0; cur.mask = '0; cur.err = err_s[k];
                        cur.stall = 0; cur.mark = cyc; cur.lat = 0;
                    end else begin
                        cur = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check({tag, " latency"}, cyc - cur.mark, cur.lat);
                        check({tag, " error"}, err_s[k], cur.err);
                        if (cur.mask != 0)
                            check({tag, " read data"}, rdata_s[k] & cur.mask, cur.data & cur.mask);
                    end
                    held_d     = rdata_s[k];
                    held_e     = err_s[k];
                    in_resp    = 1'b1;
                    stall_left = cur.stall;
                end else begin
                    check({tag, " data stable under backpressure"}, rdata_s[k], held_d);
                    check({tag, " error stable under backpressure"}, err_s[k], held_e);
                end
                if (stall_left > 0) begin
                    rsp_ready[k] = 1'b0;
                    stall_left--;
                end else begin
                    rsp_ready[k] = rand_ready[k] ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (rsp_ready[k]) begin
                    in_resp   = 1'b0;
                    just_done = 1'b1;
                end
            end else begin
                if (in_resp) begin
                    check({tag, " valid held until handshake"}, rsp_valid_s[k], 1);
                    in_resp = 1'b0;
                end
                rsp_ready[k] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic rand_traffic(input int k, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0:       a = $urandom;
                1, 2:    a = 32'h1000 + $urandom_range(0, 255);
                default: a = $urandom_range(0, 255);
            endcase
            issue(k, a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            req_valid[k]  = 1'b0;
            req_addr[k]   = '0;
            req_write[k]  = 1'b0;
            req_wdata[k]  = '0;
            req_strb[k]   = '0;
            rand_ready[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check({tag_of(k), " reset request_ready"}, req_ready_s[k], 1);
            check({tag_of(k), " reset response_valid"}, rsp_valid_s[k], 0);
            check({tag_of(k), " reset read_data"}, rdata_s[k], 0);
            check({tag_of(k), " reset error"}, err_s[k], 0);
        end

        issue(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b1);
        issue(0, 32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b1);
        issue(0, 32'h20, 1'b1, 32'hAABBCCDD, 4'hF, 0, 1'b1);
        issue(0, 32'h20, 1'b1, 32'h11223344, 4'h5, 0, 1'b1);
        issue(0, 32'h20, 1'b0, 32'h0, 4'h0, 0, 1'b1);
        issue(0, 32'h23, 1'b0, 32'h0, 4'h0, 0, 1'b1);

        issue(1, 32'h0, 1'b1, 32'h5A5A0F0F, 4'hF, 0, 1'b1);
        issue(1, 32'h0, 1'b0, 32'h0, 4'h0, 0, 1'b1);

        issue(0, 32'h10, 1'b0, 32'h0, 4'h0, 5, 1'b1);
        issue(1, 32'h0, 1'b0, 32'h0, 4'h0, 5, 1'b1);

        issue(0, 32'h0, 1'b1, 32'h01234567, 4'hF, 0, 1'b1);
        issue(0, 32'h1000, 1'b1, 32'hCAFEF00D, 4'hF, 0, 1'b1);
        issue(0, 32'h1000, 1'b0, 32'h0, 4'h0, 0, 1'b1);
        issue(0, 32'h0, 1'b0, 32'h0, 4'h0, 0, 1'b1);

        issue(0, 32'h40, 1'b1, 32'h600DF00D, 4'hF, 0, 1'b1);
        issue(0, 32'h40, 1'b0, 32'h0, 4'h0, 50, 1'b0);
        n = 0;
        while (!rsp_valid_s[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w0 response before reset", rsp_valid_s[0], 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("w0 response_valid after reset", rsp_valid_s[0], 0);
        check("w0 request_ready after reset", req_ready_s[0], 1);
        issue(0, 32'h40, 1'b0, 32'h0, 4'h0, 0, 1'b1);

        rand_ready[0] = 1'b1;
        rand_ready[1] = 1'b1;
        fork
            rand_traffic(0, 300);
            rand_traffic(1, 300);
        join
        repeat (20) @(negedge clk);
        check("w0 scoreboard drained", q0.size(), 0);
        check("w3 scoreboard drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
